exc_arbiter: RTL

EXC_ARBITER -- requirements
Module: exc_arbiter

---
 rtl/exc_arbiter_pkg.sv | 6 +
 rtl/exc_arbiter_if.sv | 27 ++
 rtl/exc_arbiter_irq_sync.sv | 16 +
 rtl/exc_arbiter.sv | 65 ++++++
 4 files changed

// File: rtl/exc_arbiter_pkg.sv
// exc_arbiter_pkg: shared FSM state type and exception constants
package exc_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ENTER, SETTLE, RETURN} state_e;
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_0180;
endpackage

// File: rtl/exc_arbiter_if.sv
// exc_arbiter_if: pipeline/CP0 side signals of the exception arbiter
interface exc_arbiter_if;
  logic [4:0] hw_irq;
  logic [7:0] sr_im;
  logic sr_ie;
  logic [31:0] epc;
  logic exc_valid;
  logic [4:0] exc_code_in;
  logic [31:0] exc_pc;
  logic [31:0] cur_pc;
  logic eret;
  logic exc_enter;
  logic [4:0] exc_code;
  logic [4:0] hw_int;
  logic [31:0] epc_din;
  logic flush;
  logic [31:0] redirect_pc;
  logic busy;
  modport master (
    output hw_irq, sr_im, sr_ie, epc, exc_valid, exc_code_in, exc_pc, cur_pc, eret,
    input exc_enter, exc_code, hw_int, epc_din, flush, redirect_pc, busy
  );
  modport slave (
    input hw_irq, sr_im, sr_ie, epc, exc_valid, exc_code_in, exc_pc, cur_pc, eret,
    output exc_enter, exc_code, hw_int, epc_din, flush, redirect_pc, busy
  );
endinterface

// File: rtl/exc_arbiter_irq_sync.sv
// irq_sync: multi-flop synchronizer for asynchronous level inputs
module irq_sync #(
  parameter int W = 5,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [D-1:0][W-1:0] sync_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[D-2:0], d_i};
  assign q_o = sync_q[D-1];
endmodule

// File: rtl/exc_arbiter.sv
// exc_arbiter: arbitrates exceptions, interrupts and eret into CP0 entry and pipeline redirect
module exc_arbiter
  import exc_arbiter_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC  = HANDLER_PC_DEF,
  parameter int          SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         reset,
  exc_arbiter_if.slave bus
);
  state_e state_q, state_d;
  logic [4:0] code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0] hw_int;
  logic irq_eligible;
  logic unused_sr_im;
  irq_sync #(.W(5), .D(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (reset),
    .d_i (bus.hw_irq),
    .q_o (hw_int)
  );
  assign unused_sr_im = ^{bus.sr_im[7], bus.sr_im[1:0]};
  assign irq_eligible = bus.sr_ie & |(hw_int & bus.sr_im[6:2]);
  // Requests are only looked at in IDLE; lower-priority ones are dropped
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    epc_d   = epc_q;
    case (state_q)
      IDLE:
        if (bus.exc_valid) begin
          state_d = ENTER;
          code_d  = bus.exc_code_in;
          epc_d   = bus.exc_pc;
        end else if (irq_eligible) begin
          state_d = ENTER;
          code_d  = EXC_INT;
          epc_d   = bus.cur_pc;
        end else if (bus.eret) begin
          state_d = RETURN;
        end
      ENTER:   state_d = SETTLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      code_q  <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
    end
  assign bus.hw_int      = hw_int;
  assign bus.exc_enter   = state_q == ENTER;
  assign bus.flush       = state_q == ENTER || state_q == RETURN;
  assign bus.redirect_pc = state_q == ENTER ? HANDLER_PC : state_q == RETURN ? bus.epc : '0;
  assign bus.exc_code    = code_q;
  assign bus.epc_din     = epc_q;
  assign bus.busy        = state_q != IDLE;
endmodule
